mux161_rr_arbiter: RTL
======================

# mux161_rr_arbiter

Round-robin arbiter and select sequencer for the 16:1 single-bit multiplexer datapath. It shares one 16:1 mux output among 16 requesters. It grants exactly one requester at a time and drives the mux's 4-bit select from the winner index. It enforces a bounded hold time and a one-cycle dead gap between owners, so downstream logic never sees a select change while a grant is asserted.

## Interface
- HOLD_MAX, default 8: maximum consecutive cycles one owner keeps the grant; legal range 0–255; 0 means unlimited hold.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; when low, no new grant is issued and a current grant is unaffected.
- req  input  16  level requests; bit k is requester k, which owns mux input i[k].
- gnt  output  16  one-hot grant, registered; all zero when no owner.
- sel  output  4  mux select, registered; equals the owner index while valid=1.
- valid  output  1  high when an owner holds the mux (equals |gnt).
- busy  output  1  high in the GRANT and GAP states.

## Operation
- State machine with three states: IDLE, GRANT, GAP. Pointer ptr[3:0] marks the highest-priority index for the next arbitration.
- Arbitration is evaluated in IDLE and GAP.
  - Winner = first k with req[k]=1, searching ptr, ptr+1, …, 15, 0, …, ptr−1 (mod-16 wrap).
  - If en=1 and req≠0: next state GRANT; sel←winner; gnt←1<<winner; hold_cnt←1.
  - Otherwise: next state IDLE; gnt=0; sel holds its value.
- GRANT, each edge:
  - Release when req[sel]=0, or when HOLD_MAX≠0 and hold_cnt==HOLD_MAX.
  - On release: gnt←0; ptr←sel+1 (mod 16, 15 wraps to 0); next state GAP; sel holds.
  - Otherwise: hold_cnt←hold_cnt+1, saturating at 255; gnt and sel unchanged.
- GAP lasts exactly one cycle with gnt=0. Arbitration at the end of GAP uses the updated ptr.
- ptr changes only on release. An idle period does not move ptr.
- Request lines from non-owners are ignored during GRANT.
- en falling during GRANT does not release the owner. Release still follows the req/hold rules, after which the block returns to IDLE until en=1.
- Exactly one gnt bit may be set at any time. sel never changes while valid=1.
- hold_cnt is an 8-bit internal counter.

## Timing
- Reset (asynchronous, rst_n=0): gnt=0, sel=0, valid=0, busy=0, ptr=0, hold_cnt=0, state IDLE. Reset asserted mid-grant clears everything immediately without a clock edge. The first arbitration after reset deassertion starts from index 0.
- Grant latency is 1 cycle: req sampled at edge t with the block in IDLE gives gnt visible after edge t.
- Release latency is 1 cycle: req[owner] sampled low at edge t gives gnt=0 after edge t.
- Owner-to-owner handoff: exactly one cycle with gnt=0 between consecutive grants, including a re-grant to the same requester.
- Hold limit: with HOLD_MAX=N and req held high, gnt stays high for exactly N cycles, then one GAP cycle follows.
- Simultaneous requests at reset: the lowest index wins, because ptr=0.
- Owner drops req in the same cycle another requester rises: normal release, then GAP, then the new arbitration.
- Wrap-around: owner 15 releases, ptr becomes 0, and the search restarts from index 0.

## Test plan
- Reset check: drive rst_n=0 mid-grant (owner 5). Required: gnt=0, sel=0, valid=0 without a clock edge. After release, req=16'h0020 gives gnt=16'h0020, sel=5 one cycle later.
- Round-robin: HOLD_MAX=0, req=16'h8421 held; each owner drops req for one cycle after 3 granted cycles. Required grant order: 0, 5, 10, 15, 0, with exactly one gnt=0 cycle between owners.
- Hold limit: HOLD_MAX=4, req=16'h0003 held constant. Required pattern: gnt=0x0001 for 4 cycles, 1 gap cycle, gnt=0x0002 for 4 cycles, 1 gap cycle, then 0x0001.
- Enable gating: en=0 with req=16'hFFFF. Required: gnt stays 0 indefinitely. Drop en during a grant of owner 3: owner keeps the grant until req[3]=0, then the block stays IDLE.
- Single requester re-grant: HOLD_MAX=2, req=16'h4000 held. Required: sel=14 throughout; gnt repeats high 2 cycles, low 1 cycle.
- Invariant checks every cycle: gnt is one-hot or zero; valid==|gnt; sel==index of the gnt bit when valid=1; sel stable while valid=1.

Source files
------------

// File: rtl/mux161_rr_arbiter.sv
// Round-robin arbiter driving the 4-bit select of a 16:1 single-bit mux.
// Grants one requester at a time, bounds hold time and inserts a one-cycle gap between owners.
module mux161_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_gnt;
    logic [15:0] w_nextGnt;
    logic [3:0]  r_sel;
    logic [3:0]  w_nextSel;
    logic [3:0]  r_ptr;
    logic [3:0]  w_nextPtr;
    logic [7:0]  r_holdCnt;
    logic [7:0]  w_nextHoldCnt;
    logic [3:0]  w_winner;
    logic        w_anyReq;
    logic        w_release;

    // Scan from the highest offset down so the nearest request at or after ptr wins.
    always_comb begin
        w_winner = r_ptr;
        for (int j = 15; j >= 0; j--) begin
            if (req[r_ptr + 4'(j)]) begin
                w_winner = r_ptr + 4'(j);
            end
        end
    end

    assign w_anyReq  = |req;
    assign w_release = !req[r_sel] || ((HOLD_MAX != 0) && (r_holdCnt == HOLD_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_holdCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_gnt     <= w_nextGnt;
            r_sel     <= w_nextSel;
            r_ptr     <= w_nextPtr;
            r_holdCnt <= w_nextHoldCnt;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextGnt     = r_gnt;
        w_nextSel     = r_sel;
        w_nextPtr     = r_ptr;
        w_nextHoldCnt = r_holdCnt;
        case (r_state)
            IDLE, GAP: begin
                if (en && w_anyReq) begin
                    w_nextState   = GRANT;
                    w_nextSel     = w_winner;
                    w_nextGnt     = 16'd1 << w_winner;
                    w_nextHoldCnt = 8'd1;
                end else begin
                    w_nextState = IDLE;
                    w_nextGnt   = '0;
                end
            end
            GRANT: begin
                // ptr only advances here, so idle periods never disturb fairness.
                if (w_release) begin
                    w_nextState = GAP;
                    w_nextGnt   = '0;
                    w_nextPtr   = r_sel + 4'd1;
                end else if (r_holdCnt != 8'hFF) begin
                    w_nextHoldCnt = r_holdCnt + 8'd1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextGnt   = '0;
            end
        endcase
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = |r_gnt;
    assign busy  = (r_state != IDLE);

endmodule
